booth_seq_multiplier: RTL

BOOTH_SEQ_MULTIPLIER -- requirements
Module: booth_seq_multiplier

---
 rtl/booth_pkg.sv | 20 ++
 rtl/booth_recode_step.sv | 63 ++++++
 rtl/booth_seq_multiplier.sv | 120 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: FSM state encoding and
// the recoding-select codes chosen by each Booth step.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Which multiple of M a Booth step adds to the partial product.
    typedef enum logic [2:0] {
        ZERO   = 3'd0,
        ADD_M  = 3'd1,
        SUB_M  = 3'd2,
        ADD_2M = 3'd3,
        SUB_2M = 3'd4
    } recode_sel_t;

endpackage

// File: rtl/booth_recode_step.sv
// One combinational Booth step: recode the low multiplier bits, add the
// selected multiple of M to A, then arithmetic-shift {A,Q,Q_-1} right.
// Define BOOTH_RADIX4_EN for radix-4 (two bits per step); default is radix-2.
module booth_recode_step
    import booth_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W+1:0] a_in,
    input  logic [DATA_W-1:0] q_in,
    input  logic              q_m1_in,
    input  logic [DATA_W-1:0] m_in,
    output logic [DATA_W+1:0] a_out,
    output logic [DATA_W-1:0] q_out,
    output logic              q_m1_out
);

    logic [DATA_W+1:0] m_ext;
    logic [DATA_W+1:0] m2_ext;
    logic [DATA_W+1:0] addend;
    logic [DATA_W+1:0] sum;
    recode_sel_t       sel;

    // Recode, select the addend, add, and shift.
    always_comb begin
        m_ext  = {{2{m_in[DATA_W-1]}}, m_in};
        m2_ext = {m_ext[DATA_W:0], 1'b0};
        sel    = ZERO;
`ifdef BOOTH_RADIX4_EN
        case ({q_in[1], q_in[0], q_m1_in})
            3'b001, 3'b010: sel = ADD_M;
            3'b011:         sel = ADD_2M;
            3'b100:         sel = SUB_2M;
            3'b101, 3'b110: sel = SUB_M;
            default:        sel = ZERO;
        endcase
`else
        case ({q_in[0], q_m1_in})
            2'b01:   sel = ADD_M;
            2'b10:   sel = SUB_M;
            default: sel = ZERO;
        endcase
`endif
        case (sel)
            ADD_M:   addend = m_ext;
            SUB_M:   addend = -m_ext;
            ADD_2M:  addend = m2_ext;
            SUB_2M:  addend = -m2_ext;
            default: addend = '0;
        endcase
        sum = a_in + addend;
`ifdef BOOTH_RADIX4_EN
        a_out    = {{2{sum[DATA_W+1]}}, sum[DATA_W+1:2]};
        q_out    = {sum[1:0], q_in[DATA_W-1:2]};
        q_m1_out = q_in[1];
`else
        a_out    = {sum[DATA_W+1], sum[DATA_W+1:1]};
        q_out    = {sum[0], q_in[DATA_W-1:1]};
        q_m1_out = q_in[0];
`endif
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential signed Booth multiplier with valid/ready on both sides.
// Handshake: an operand pair is taken on an edge with in_valid && in_ready;
// the product is handed off on an edge with out_valid && out_ready, and
// product stays stable while out_valid waits for out_ready.
// Define BOOTH_RADIX4_EN for radix-4 recoding (DATA_W/2 steps instead of DATA_W).
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     multiplicand,
    input  logic [DATA_W-1:0]     multiplier,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   product,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

`ifdef BOOTH_RADIX4_EN
    localparam int STEPS = DATA_W / 2;
`else
    localparam int STEPS = DATA_W;
`endif
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W+1:0]     a_q, a_d;
    logic [DATA_W-1:0]     q_q, q_d;
    logic                  q_m1_q, q_m1_d;
    logic [DATA_W-1:0]     m_q, m_d;
    logic [2*DATA_W-1:0]   prod_q, prod_d;

    logic [DATA_W+1:0]     a_step;
    logic [DATA_W-1:0]     q_step;
    logic                  q_m1_step;

    booth_recode_step #(.DATA_W(DATA_W)) u_step (
        .a_in     (a_q),
        .q_in     (q_q),
        .q_m1_in  (q_m1_q),
        .m_in     (m_q),
        .a_out    (a_step),
        .q_out    (q_step),
        .q_m1_out (q_m1_step)
    );

    // Next-state and datapath updates; everything holds unless the state acts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        q_d     = q_q;
        q_m1_d  = q_m1_q;
        m_d     = m_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = multiplicand;
                    a_d     = '0;
                    q_d     = multiplier;
                    q_m1_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d    = a_step;
                q_d    = q_step;
                q_m1_d = q_m1_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    prod_d  = {a_step[DATA_W-1:0], q_step};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            q_m1_q  <= 1'b0;
            m_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q_m1_q  <= q_m1_d;
            m_q     <= m_d;
            prod_q  <= prod_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = prod_q;
    assign state_dbg = state_q;

endmodule
